// File: rtl/avg_dc_block_mc_pkg.sv
// Shared definitions for the sliding-window averager / DC remover.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package avg_pkg;

  // mode_i encodings, sampled together with valid_i
  localparam logic MODE_DC   = 1'b0;  // output x - mean
  localparam logic MODE_MEAN = 1'b1;  // output mean

  // Width of the clip helper's input. Differences are carried sign-extended
  // to this width so the helper serves any sample width up to 63 bits.
  localparam int CLIP_W = 64;

  // Running-sum width: DEPTH samples of WIDTH bits never overflow this.
  function automatic int sumw(input int width, input int log2_depth);
    return width + log2_depth;
  endfunction

  // Clamp a signed value to the w-bit signed range.
  // Returns {clamped_flag, clamped_value}. The value is sign-extended to
  // CLIP_W bits, so callers take the low w bits.
  function automatic logic [CLIP_W:0] sat_clip(input logic signed [CLIP_W-1:0] d,
                                               input int w);
    logic signed [CLIP_W-1:0] hi;
    logic signed [CLIP_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (d > hi)      return {1'b1, hi};
    else if (d < lo) return {1'b1, lo};
    else             return {1'b0, d};
  endfunction

endpackage

// File: rtl/avg_dc_block_mc_ring_ram.sv
// Ring buffer holding the last DEPTH sample sets (all channels in one word).
// Latency: read is combinational; write lands at the clock edge.
// Backpressure: none; one write per cycle.
// Ports: clk_i clock, we_i write enable, addr_i shared read/write address,
//        wdat_i write word, rdat_o word currently stored at addr_i (pre-write).
module avg_ring_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdat_i,
  output logic [DW-1:0] rdat_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Async read sees the word before this cycle's write: the evicted sample.
  assign rdat_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdat_i;
  end

endmodule

// File: rtl/avg_dc_block_mc.sv
// Multi-channel sliding-window mean / DC remover over the last 2**LOG2_DEPTH samples.
// Latency: 1 cycle from valid_i to valid_o; data_o/sat_o hold between valids.
// Backpressure: none; accepts a sample set every cycle.
// Ports: clk, rst (sync, active-high), valid_i/flush_i/mode_i/data_i in;
//        valid_o/data_o/primed_o/sat_o out. data_i/data_o pack ch0 in the LSBs.
module avg_dc_block_mc
  import avg_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 7,
  parameter int CHANNELS   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic                      flush_i,
  input  logic                      mode_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  output logic                      valid_o,
  output logic [CHANNELS*WIDTH-1:0] data_o,
  output logic                      primed_o,
  output logic [CHANNELS-1:0]       sat_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = sumw(WIDTH, LOG2_DEPTH);

  logic                      accept;
  logic                      primed;
  logic [LOG2_DEPTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]       fill_q, fill_d;
  logic [CHANNELS*WIDTH-1:0] old_word;
  logic [CHANNELS*WIDTH-1:0] data_d, data_q;
  logic [CHANNELS-1:0]       sat_d, sat_q;
  logic                      valid_q;

  assign accept = valid_i & ~flush_i;

  // fill saturates at exactly DEPTH, so its MSB alone means "window full".
  assign primed   = fill_q[LOG2_DEPTH];
  assign wr_ptr_d = wr_ptr_q + 1'b1;
  assign fill_d   = primed ? fill_q : fill_q + 1'b1;

  avg_ring_ram #(
    .AW (LOG2_DEPTH),
    .DW (CHANNELS*WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (accept),
    .addr_i (wr_ptr_q),
    .wdat_i (data_i),
    .rdat_o (old_word)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [WIDTH-1:0]  x;
    logic signed [WIDTH-1:0]  old;
    logic signed [SW-1:0]     sum_q, sum_d;
    logic signed [SW-1:0]     mean;
    logic signed [CLIP_W-1:0] diff;
    logic [CLIP_W:0]          clip;
    logic                     unused_clip_hi;

    assign x = data_i[c*WIDTH +: WIDTH];
    // Until the window is full the RAM slot holds nothing real (or stale
    // pre-flush data), so nothing is evicted.
    assign old = primed ? old_word[c*WIDTH +: WIDTH] : '0;
    // The final sum always fits SW bits, so modular intermediate is exact.
    assign sum_d = sum_q + SW'(x) - SW'(old);
    assign mean  = sum_d >>> LOG2_DEPTH;
    assign diff  = CLIP_W'(x) - CLIP_W'(mean);
    assign clip  = sat_clip(diff, WIDTH);
    assign unused_clip_hi = ^clip[CLIP_W-1:WIDTH];

    // The mean of WIDTH-bit samples always fits WIDTH bits: no clamp needed.
    assign data_d[c*WIDTH +: WIDTH] = (mode_i == MODE_MEAN) ? mean[WIDTH-1:0]
                                                            : clip[WIDTH-1:0];
    assign sat_d[c] = (mode_i == MODE_DC) & clip[CLIP_W];

    always_ff @(posedge clk) begin
      if (rst || flush_i) sum_q <= '0;
      else if (accept)    sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (accept) begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sat_q   <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        data_q <= data_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign sat_o    = sat_q;
  assign primed_o = primed;

endmodule

// File: tb/tb_avg_dc_block_mc.sv
// Directed-vector bench for avg_dc_block_mc (WIDTH=16, DEPTH=4, two channels).
// Latency: each vector's expectations are the outputs one clock after it is driven.
// Backpressure: none exercised; the DUT has none.
module tb_avg_dc_block_mc;

  localparam int W = 16;
  localparam int L = 2;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_i, flush_i, mode_i;
  logic [C*W-1:0] data_i;
  logic           valid_o, primed_o;
  logic [C*W-1:0] data_o;
  logic [C-1:0]   sat_o;

  int checks = 0;
  int errors = 0;

  avg_dc_block_mc #(.WIDTH(W), .LOG2_DEPTH(L), .CHANNELS(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .flush_i  (flush_i),
    .mode_i   (mode_i),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .primed_o (primed_o),
    .sat_o    (sat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v, f, m;
    int d0, d1;
    bit ev;
    int e0, e1, es;
    bit ep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit v, input bit f, input bit m, input int d0, input int d1,
                     input bit ev, input int e0, input int e1, input int es, input bit ep);
    vec_t t;
    t.v = v; t.f = f; t.m = m; t.d0 = d0; t.d1 = d1;
    t.ev = ev; t.e0 = e0; t.e1 = e1; t.es = es; t.ep = ep;
    vecs.push_back(t);
  endtask

  task automatic check(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return just after the rising edge.
  task automatic drive(input bit v, input bit f, input bit m, input int d0, input int d1);
    @(negedge clk);
    valid_i = v;
    flush_i = f;
    mode_i  = m;
    data_i  = {d1[W-1:0], d0[W-1:0]};
    @(posedge clk);
    #1;
  endtask

  function automatic int ch(input int c);
    return int'($signed(data_o[c*W +: W]));
  endfunction

  // Behavioural reference for the random section
  int  m_ring [C][4];
  int  m_sum  [C];
  int  m_ptr, m_fill;

  initial begin
    int n_out;
    int xs [C];
    int ex [C];
    int es;
    bit md;

    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; mode_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  0, int'(valid_o),  0);
    check("rst_data",   0, int'(data_o),   0);
    check("rst_primed", 0, int'(primed_o), 0);
    check("rst_sat",    0, int'(sat_o),    0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp-up in DC mode: means 1,2,3,4,4 on ch0, negatives on ch1
    add(1,0,0, 4,-4, 1, 3,-3, 0, 0);
    add(1,0,0, 4,-4, 1, 2,-2, 0, 0);
    add(1,0,0, 4,-4, 1, 1,-1, 0, 0);
    add(1,0,0, 4,-4, 1, 0, 0, 0, 1);
    add(1,0,0, 4,-4, 1, 0, 0, 0, 1);
    add(0,1,0, 0, 0, 0, 0, 0, 0, 0);
    // Floor toward -inf in mean mode
    add(1,0,1,-1, 5, 1,-1, 1, 0, 0);
    add(1,0,1, 0, 5, 1,-1, 2, 0, 0);
    add(1,0,1, 0, 5, 1,-1, 3, 0, 0);
    add(1,0,1, 0, 5, 1,-1, 5, 0, 1);
    add(0,1,0, 0, 0, 0,-1, 5, 0, 0);
    // Step from +1000 to -1000 after two full windows
    add(1,0,0, 1000,0, 1, 750,0, 0, 0);
    add(1,0,0, 1000,0, 1, 500,0, 0, 0);
    add(1,0,0, 1000,0, 1, 250,0, 0, 0);
    for (int i = 0; i < 5; i++) add(1,0,0, 1000,0, 1, 0,0, 0, 1);
    add(1,0,0,-1000,0, 1,-1500,0, 0, 1);
    add(1,0,0,-1000,0, 1,-1000,0, 0, 1);
    add(1,0,0,-1000,0, 1, -500,0, 0, 1);
    add(1,0,0,-1000,0, 1,    0,0, 0, 1);
    add(0,1,0, 0, 0, 0, 0, 0, 0, 0);
    // Full-scale step: both channels clamp in opposite directions
    add(1,0,0, 32767,-32768, 1, 24576,-24576, 0, 0);
    add(1,0,0, 32767,-32768, 1, 16384,-16384, 0, 0);
    add(1,0,0, 32767,-32768, 1,  8192, -8192, 0, 0);
    add(1,0,0, 32767,-32768, 1,     0,     0, 0, 1);
    add(1,0,0,-32768, 32767, 1,-32768, 32767, 3, 1);
    add(1,0,1,     0,     0, 1,  8191, -8193, 0, 1);
    add(0,0,0,     0,     0, 0,  8191, -8193, 0, 1);
    add(0,1,0,     0,     0, 0,  8191, -8193, 0, 0);
    // Flush colliding with valid drops the sample; stale RAM must stay masked
    for (int k = 1; k <= 10; k++)
      add(1,0,1, 100,200, 1, (k < 4) ? 25*k : 100, (k < 4) ? 50*k : 200, 0, (k >= 4));
    add(1,1,1, 5000,5000, 0, 100,200, 0, 0);
    add(1,0,1, 40,80, 1, 10,20, 0, 0);
    add(1,0,1, 40,80, 1, 20,40, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].f, vecs[i].m, vecs[i].d0, vecs[i].d1);
      check("valid_o",  i, int'(valid_o),  int'(vecs[i].ev));
      check("data_ch0", i, ch(0),          vecs[i].e0);
      check("data_ch1", i, ch(1),          vecs[i].e1);
      check("sat_o",    i, int'(sat_o),    vecs[i].es);
      check("primed_o", i, int'(primed_o), int'(vecs[i].ep));
    end

    // Reset mid-stream clears outputs and the window
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b1; data_i = {16'sd7, 16'sd7};
    @(posedge clk);
    #1;
    check("midrst_valid",  0, int'(valid_o),  0);
    check("midrst_data",   0, int'(data_o),   0);
    check("midrst_primed", 0, int'(primed_o), 0);
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0;

    // Back-to-back random stream against the reference model
    m_ptr = 0; m_fill = 0;
    for (int c = 0; c < C; c++) m_sum[c] = 0;
    n_out = 0;
    for (int i = 0; i < 12; i++) begin
      md = 1'($urandom_range(0, 1));
      es = 0;
      for (int c = 0; c < C; c++) begin
        int old, mean, d;
        xs[c] = int'($urandom_range(0, 65535)) - 32768;
        old = (m_fill == 4) ? m_ring[c][m_ptr] : 0;
        m_sum[c] = m_sum[c] + xs[c] - old;
        m_ring[c][m_ptr] = xs[c];
        mean = m_sum[c] >>> 2;
        d = xs[c] - mean;
        if (md) ex[c] = mean;
        else if (d > 32767)  begin ex[c] = 32767;  es |= (1 << c); end
        else if (d < -32768) begin ex[c] = -32768; es |= (1 << c); end
        else ex[c] = d;
      end
      m_ptr = (m_ptr + 1) % 4;
      if (m_fill < 4) m_fill++;
      drive(1'b1, 1'b0, md, xs[0], xs[1]);
      if (valid_o) n_out++;
      check("rnd_ch0",    i, ch(0),          ex[0]);
      check("rnd_ch1",    i, ch(1),          ex[1]);
      check("rnd_sat",    i, int'(sat_o),    es);
      check("rnd_primed", i, int'(primed_o), int'(m_fill == 4));
    end
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    check("rnd_valid_count", 0, n_out, 12);
    check("idle_valid",      0, int'(valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
